// File: rtl/oddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// oddr_tx_serializer : valid/ready parallel words out two bits per clock on a
//                      single DDR pin through an ODDR2 (C0 alignment, sync reset)
// Revision: 1.0
// ============================================================================
module oddr_tx_serializer #(
  parameter int   W        = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic         c,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [1:0]   pair,
  output logic         frame,
  output logic         sof,
  output logic         busy,
  output logic         q
);
  localparam int            NPAIR     = W / 2;
  localparam int            CW        = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(NPAIR - 1);
  localparam logic [1:0]    IDLE_PAIR = {IDLE_BIT, IDLE_BIT};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  hold;
  logic [W-1:0]  sh;
  logic          hold_full;
  logic          rst_seen;
  logic [CW-1:0] cnt;
  logic          xfer;
  logic          last;
  logic          c_n;

  // rst_seen keeps din_ready low for every cycle in which reset was sampled
  assign din_ready = ~hold_full & ~rst_seen;
  assign xfer      = din_valid & din_ready;
  assign last      = (cnt == CNT_LAST);
  assign busy      = (state == SHIFT) | hold_full;
  assign c_n       = ~c;

  always_ff @(posedge c) begin
    rst_seen <= r;
    if (r) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      pair      <= IDLE_PAIR;
      frame     <= 1'b0;
      sof       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state <= SHIFT;
            pair  <= din[1:0];
            sh    <= din >> 2;
            cnt   <= '0;
            sof   <= 1'b1;
            frame <= 1'b1;
          end else begin
            pair  <= IDLE_PAIR;
            frame <= 1'b0;
            sof   <= 1'b0;
          end
        end
        SHIFT: begin
          if (!last) begin
            pair  <= sh[1:0];
            sh    <= sh >> 2;
            cnt   <= cnt + CW'(1);
            sof   <= 1'b0;
            frame <= 1'b1;
            if (xfer) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // din_ready is low here, so no new word can arrive this edge
            pair      <= hold[1:0];
            sh        <= hold >> 2;
            cnt       <= '0;
            sof       <= 1'b1;
            frame     <= 1'b1;
            hold_full <= 1'b0;
          end else if (xfer) begin
            pair  <= din[1:0];
            sh    <= din >> 2;
            cnt   <= '0;
            sof   <= 1'b1;
            frame <= 1'b1;
          end else begin
            state <= IDLE;
            pair  <= IDLE_PAIR;
            frame <= 1'b0;
            sof   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  oddr_tx_serializer_oddr2 u_oddr (
    .c0  (c),
    .c1  (c_n),
    .d0  (pair[0]),
    .d1  (pair[1]),
    .rst (r),
    .q   (q)
  );
endmodule

// Behavioural ODDR2, DDR_ALIGNMENT "C0", SRTYPE "SYNC": both bits sampled on C0,
// d0 driven while C0 is high, d1 driven after the C1 edge.
module oddr_tx_serializer_oddr2 (
  input  logic c0,
  input  logic c1,
  input  logic d0,
  input  logic d1,
  input  logic rst,
  output logic q
);
  logic q0;
  logic q1;
  logic d1_q;

  always_ff @(posedge c0) begin
    if (rst) begin
      q0   <= 1'b0;
      d1_q <= 1'b0;
    end else begin
      q0   <= d0;
      d1_q <= d1;
    end
  end

  always_ff @(posedge c1) begin
    if (rst) q1 <= 1'b0;
    else     q1 <= d1_q;
  end

  assign q = c0 ? q0 : q1;
endmodule
`default_nettype wire

// File: tb/tb_oddr_tx_serializer.sv
`default_nettype none
// tb_oddr_tx_serializer : directed checks on a W=8 instance plus a random-valid
// stream compared against a scoreboard on W=8 and W=16 instances.
module tb_oddr_tx_serializer;
  localparam int NW = 1000;

  logic        c = 1'b0;
  logic        r = 1'b1;
  logic [1:0]  v = 2'b00;
  logic [15:0] d [2];
  logic [1:0]  rdy, fr, sf, bz, qq;
  logic [1:0]  pr8, pr16;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [1:0]  pa [4]  = '{2'b01, 2'b01, 2'b10, 2'b10};
  logic [7:0]  cw [3]  = '{8'h0F, 8'hF0, 8'h3C};
  logic [11:0] rdy_exp = 12'b1111_0001_0001;
  logic [7:0]  cur;

  logic [15:0] q8 [$];
  logic [15:0] q16 [$];
  logic [15:0] asm_w [2];
  logic [15:0] expw;
  logic [1:0]  acc;
  logic [1:0]  pv;
  int          sent [2];
  int          got [2];
  int          frames [2];
  int          nb [2];
  int          wi;

  always #5 c = ~c;

  oddr_tx_serializer #(.W(8), .IDLE_BIT(1'b0)) dut8 (
    .c(c), .r(r), .din(d[0][7:0]), .din_valid(v[0]), .din_ready(rdy[0]),
    .pair(pr8), .frame(fr[0]), .sof(sf[0]), .busy(bz[0]), .q(qq[0])
  );

  oddr_tx_serializer #(.W(16), .IDLE_BIT(1'b0)) dut16 (
    .c(c), .r(r), .din(d[1]), .din_valid(v[1]), .din_ready(rdy[1]),
    .pair(pr16), .frame(fr[1]), .sof(sf[1]), .busy(bz[1]), .q(qq[1])
  );

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge of a W=8 word
  task automatic expect_word8(input string tag, input logic [7:0] w);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check({tag, "_pair"},  16'(pr8),   16'(w[2*k +: 2]));
      check({tag, "_sof"},   16'(sf[0]), 16'(k == 0));
      check({tag, "_frame"}, 16'(fr[0]), 16'd1);
    end
    tick();
    check({tag, "_end_frame"}, 16'(fr[0]), 16'd0);
    check({tag, "_end_pair"},  16'(pr8),   16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d[0] = '0;
    d[1] = '0;
    tick();
    tick();
    check("rst_pair",  16'(pr8),    16'd0);
    check("rst_frame", 16'(fr[0]),  16'd0);
    check("rst_sof",   16'(sf[0]),  16'd0);
    check("rst_busy",  16'(bz[0]),  16'd0);
    check("rst_ready", 16'(rdy[0]), 16'd0);
    check("rst_q_hi",  16'(qq[0]),  16'd0);
    #5;
    check("rst_q_lo",  16'(qq[0]),  16'd0);
    r = 1'b0;
    tick();
    check("ready_after_rst", 16'(rdy[0]), 16'd1);

    // Single word A5 with pin-level check
    d[0] = 16'h00A5;
    v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        check("a5_pair",  16'(pr8),   16'(pa[k]));
        check("a5_sof",   16'(sf[0]), 16'(k == 0));
        check("a5_frame", 16'(fr[0]), 16'd1);
      end else begin
        check("a5_end_frame", 16'(fr[0]), 16'd0);
        check("a5_end_pair",  16'(pr8),   16'd0);
        check("a5_end_busy",  16'(bz[0]), 16'd0);
      end
      check("a5_q_hi", 16'(qq[0]), (k == 0) ? 16'd0 : 16'(pa[k-1][0]));
      #5;
      check("a5_q_lo", 16'(qq[0]), (k == 0) ? 16'd0 : 16'(pa[k-1][1]));
      if (k < 4) tick();
    end

    // Back-to-back words with backpressure while hold is full
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        d[0] = 16'h000F;
        v[0] = 1'b1;
      end else if (k == 1) d[0] = 16'h00F0;
      else if (k == 2) d[0] = 16'h003C;
      else if (k == 6) v[0] = 1'b0;
      tick();
      cur = cw[k/4];
      check("cont_frame", 16'(fr[0]),  16'd1);
      check("cont_sof",   16'(sf[0]),  16'(k % 4 == 0));
      check("cont_pair",  16'(pr8),    16'(cur[2*(k%4) +: 2]));
      check("cont_ready", 16'(rdy[0]), 16'(rdy_exp[k]));
    end
    tick();
    check("cont_end_frame", 16'(fr[0]), 16'd0);

    // Reset at pair 2 of a word with a second word held
    d[0] = 16'h00C3;
    v[0] = 1'b1;
    tick();
    d[0] = 16'h007E;
    tick();
    v[0] = 1'b0;
    tick();
    check("mid_busy_pre",  16'(bz[0]),  16'd1);
    check("mid_ready_pre", 16'(rdy[0]), 16'd0);
    r = 1'b1;
    tick();
    check("mid_rst_pair",  16'(pr8),   16'd0);
    check("mid_rst_frame", 16'(fr[0]), 16'd0);
    check("mid_rst_busy",  16'(bz[0]), 16'd0);
    check("mid_rst_sof",   16'(sf[0]), 16'd0);
    r = 1'b0;
    tick();
    check("mid_ready_post", 16'(rdy[0]), 16'd1);
    for (int k = 0; k < 6; k++) begin
      check("mid_no_frame", 16'(fr[0]), 16'd0);
      tick();
    end
    d[0] = 16'h0081;
    v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    expect_word8("w81", 8'h81);

    // Gap then a new word
    d[0] = 16'h005A;
    v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("gap_frame", 16'(fr[0]), 16'd0);
    check("gap_busy",  16'(bz[0]), 16'd0);
    d[0] = 16'h0001;
    v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    expect_word8("w01", 8'h01);

    // Random valid stream on both widths
    r = 1'b1;
    tick();
    r = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      sent[i] = 0; got[i] = 0; frames[i] = 0; nb[i] = 0; asm_w[i] = '0;
    end
    for (int cyc = 0; cyc < 40000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        acc[i] = v[i] & rdy[i];
        if (acc[i]) begin
          if (i == 0) q8.push_back(d[i]);
          else        q16.push_back(d[i]);
          sent[i]++;
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        wi = (i == 0) ? 8 : 16;
        pv = (i == 0) ? pr8 : pr16;
        if (fr[i]) begin
          frames[i]++;
          check((i == 0) ? "r8_sof" : "r16_sof", 16'(sf[i]), 16'(nb[i] == 0));
          asm_w[i][nb[i] +: 2] = pv;
          nb[i] += 2;
          if (nb[i] == wi) begin
            if (i == 0) begin
              check("r8_extra_word", 16'(q8.size() != 0), 16'd1);
              expw = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
            end else begin
              check("r16_extra_word", 16'(q16.size() != 0), 16'd1);
              expw = (q16.size() != 0) ? q16.pop_front() : 16'hxxxx;
            end
            check((i == 0) ? "r8_word" : "r16_word", asm_w[i], expw);
            nb[i] = 0;
            got[i]++;
          end
        end
        if (acc[i] || !v[i]) begin
          if (sent[i] < NW) begin
            v[i] = ($urandom_range(0, 3) != 0);
            d[i] = 16'($urandom) & ((i == 0) ? 16'h00FF : 16'hFFFF);
          end else begin
            v[i] = 1'b0;
          end
        end
      end
      if (got[0] == NW && got[1] == NW) break;
    end
    tick();
    check("r8_words",   16'(got[0]),    16'(NW));
    check("r16_words",  16'(got[1]),    16'(NW));
    check("r8_frames",  16'(frames[0]), 16'(NW * 4));
    check("r16_frames", 16'(frames[1]), 16'(NW * 8));
    check("r_busy_end", 16'(bz),        16'd0);
    check("r_q_end",    16'(qq),        16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
